id_stage: RTL
=============

# id_stage

Instruction-decode stage of the MIPS pipeline, directly upstream of the execute stage. It decodes the 32-bit instruction held in IF/ID, reads the 32×32 register file (with write-back bypass), sign- or zero-extends the immediate, and generates the ALU and memory control. Results are registered into the ID/EX pipeline register, whose outputs drive the execute stage's operand, immediate, ALU-code and mux-select inputs. It also detects load-use hazards and inserts bubbles on stall or flush.

## Interface
Parameters:
- NB_DATA, 32, register/data width
- NB_INST, 32, instruction and PC width
- NB_OP, 6, ALU code width (MIPS funct encoding)
- NB_REG, 5, register address width

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  IF/ID holds a valid instruction
- i_instruction  in  NB_INST  instruction from IF/ID
- i_pc  in  NB_INST  PC+4 of that instruction
- i_wb_enable  in  1  write-back write strobe
- i_wb_addr  in  NB_REG  write-back destination
- i_wb_data  in  NB_DATA  write-back data
- i_ex_flush  in  1  squash the instruction currently in ID
- o_stall  out  1  combinational; IF must hold PC and IF/ID this cycle
- o_valid  out  1  ID/EX holds a real instruction
- o_pc  out  NB_INST  registered i_pc
- o_sign_extend  out  NB_DATA  extended immediate
- o_data_1, o_data_2  out  NB_DATA  rs and rt read data
- o_code  out  NB_OP  ALU operation code
- o_selector_mux_A  out  1  0 selects o_data_1; 1 selects o_pc
- o_selector_mux_B  out  1  0 selects o_data_2; 1 selects o_sign_extend
- o_rs, o_rt, o_write_reg  out  NB_REG  source fields and final destination register
- o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg  out  1  downstream control

## Operation
- Register file: 32 entries, r0 reads 0 and is never written.
  - Write occurs on the rising edge when i_wb_enable=1 and i_wb_addr≠0.
  - Reads are combinational with bypass: if i_wb_enable=1 and i_wb_addr equals the read address (≠0), the read returns i_wb_data.
- Decode, using opcode = instr[31:26]:
  - 000000 (R-type): o_code = funct (instr[5:0]); selB=0; o_write_reg = rd; reg_write=1.
  - 001000 ADDI: o_code = 100000; immediate sign-extended; selB=1; o_write_reg = rt; reg_write=1.
  - 001100 ANDI / 001101 ORI: o_code = 100100 / 100101; immediate zero-extended; selB=1; o_write_reg = rt; reg_write=1.
  - 100011 LW: o_code = 100000; sign-extend; selB=1; mem_read=1; mem_to_reg=1; reg_write=1; o_write_reg = rt.
  - 101011 SW: o_code = 100000; sign-extend; selB=1; mem_write=1; reg_write=0.
  - o_selector_mux_A is 0 for every supported opcode.
  - Any other opcode is decoded as a bubble.
- Bubble: o_valid=0; reg_write, mem_read, mem_write, mem_to_reg, selA, selB all 0. Data fields are don't-care but are driven to 0.
- Load-use hazard: hazard=1 when all of the following hold:
  - o_valid=1, o_mem_read=1, and o_rt≠0;
  - o_rt equals the current rs, or equals the current rt when the current opcode is R-type or SW;
  - i_valid=1.
- o_stall = hazard AND NOT i_ex_flush.
- ID/EX next state is chosen by priority:
  1. reset → all zero;
  2. i_ex_flush → bubble;
  3. hazard → bubble;
  4. i_valid=0 → bubble;
  5. otherwise → the decoded instruction.

## Timing
- Reset: every output is 0, including o_stall (with ID/EX cleared, no hazard can exist). All 32 registers are cleared. Reset takes priority over a simultaneous write-back.
- Latency: an instruction present at rising edge N appears on the ID/EX outputs immediately after edge N.
- Write-back and read in the same cycle: the new value is captured into ID/EX at that edge (bypass).
- Stall: o_stall is asserted in the cycle of detection. The stalled instruction stays in IF/ID and re-decodes next cycle, when the hazard has cleared. This gives exactly one bubble per load-use pair.
- Flush and hazard in the same cycle: flush wins, o_stall=0, and a bubble is inserted.
- Reset mid-stall: the next cycle shows o_stall=0 and o_valid=0.

## Test plan
- **Reset:** assert i_reset for 2 cycles with i_valid=1 → all outputs 0; afterwards every register reads 0.
- **Bypass and R-type decode:**
  - Write r2 = 0x0000000F with i_wb_enable in the same cycle as ADD r3,r2,r1 (0x00411820), with r1 = 0x000000F0 pre-loaded.
  - Required: o_data_1 = 0x0F, o_data_2 = 0xF0, o_code = 100000, selB=0, o_write_reg=3, o_valid=1.
- **Immediate extension:**
  - ADDI r4,r0,-1 → o_sign_extend = 0xFFFFFFFF, selB=1, o_write_reg=4.
  - ORI r4,r0,0xFFFF → o_sign_extend = 0x0000FFFF, o_code = 100101.
- **Load-use hazard:** LW r5,0(r0) followed by ADD r6,r5,r5 → o_stall=1 for exactly one cycle, one bubble (o_valid=0), then ADD with o_rs=5.
  - LW r0 followed by a use of r0 → no stall.
- **Flush over hazard:** same LW/ADD pair with i_ex_flush=1 in the hazard cycle → o_stall=0, bubble captured.
- **r0 protection and unsupported opcode:**
  - Write-back to r0 of 0xDEADBEEF → r0 still reads 0.
  - Opcode 111111 → bubble, o_valid=0.

Source files
------------

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: register file with write-back bypass, decode,
// immediate extension, load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_INST = 32,
  parameter int NB_OP   = 6,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_INST-1:0] i_instruction,
  input  logic [NB_INST-1:0] i_pc,
  input  logic               i_wb_enable,
  input  logic [NB_REG-1:0]  i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  input  logic               i_ex_flush,
  output logic               o_stall,
  output logic               o_valid,
  output logic [NB_INST-1:0] o_pc,
  output logic [NB_DATA-1:0] o_sign_extend,
  output logic [NB_DATA-1:0] o_data_1,
  output logic [NB_DATA-1:0] o_data_2,
  output logic [NB_OP-1:0]   o_code,
  output logic               o_selector_mux_A,
  output logic               o_selector_mux_B,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_write_reg,
  output logic               o_reg_write,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_mem_to_reg
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_ADDI  = 6'b001000,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [NB_OP-1:0] {
    ALU_ADD = 6'b100000,
    ALU_AND = 6'b100100,
    ALU_OR  = 6'b100101
  } alu_e;

  logic [NB_DATA-1:0] regs [32];

  logic [5:0]         opcode;
  logic [NB_REG-1:0]  rs, rt, rd;
  logic [15:0]        imm;
  logic [NB_DATA-1:0] sext_imm, zext_imm;
  logic [NB_DATA-1:0] rd_data_1, rd_data_2;
  logic               rt_used, hazard;

  logic               nxt_valid, nxt_sel_a, nxt_sel_b;
  logic [NB_INST-1:0] nxt_pc;
  logic [NB_DATA-1:0] nxt_sext, nxt_data_1, nxt_data_2;
  logic [NB_OP-1:0]   nxt_code;
  logic [NB_REG-1:0]  nxt_rs, nxt_rt, nxt_write_reg;
  logic               nxt_reg_write, nxt_mem_read, nxt_mem_write, nxt_mem_to_reg;

  assign opcode   = i_instruction[31:26];
  assign rs       = i_instruction[25:21];
  assign rt       = i_instruction[20:16];
  assign rd       = i_instruction[15:11];
  assign imm      = i_instruction[15:0];
  assign sext_imm = {{(NB_DATA-16){imm[15]}}, imm};
  assign zext_imm = {{(NB_DATA-16){1'b0}}, imm};

  // r0 is never written, so regs[0] stays zero and needs no read-side guard
  always_comb begin
    rd_data_1 = regs[rs];
    rd_data_2 = regs[rt];
    if (i_wb_enable && (i_wb_addr != '0) && (i_wb_addr == rs)) rd_data_1 = i_wb_data;
    if (i_wb_enable && (i_wb_addr != '0) && (i_wb_addr == rt)) rd_data_2 = i_wb_data;
  end

  assign rt_used = (opcode == OP_RTYPE) || (opcode == OP_SW);
  assign hazard  = o_valid && o_mem_read && (o_rt != '0) && i_valid &&
                   ((o_rt == rs) || (rt_used && (o_rt == rt)));
  assign o_stall = hazard && !i_ex_flush;

  always_comb begin
    nxt_valid      = 1'b0;
    nxt_sel_a      = 1'b0;
    nxt_sel_b      = 1'b0;
    nxt_pc         = '0;
    nxt_sext       = '0;
    nxt_data_1     = '0;
    nxt_data_2     = '0;
    nxt_code       = '0;
    nxt_rs         = '0;
    nxt_rt         = '0;
    nxt_write_reg  = '0;
    nxt_reg_write  = 1'b0;
    nxt_mem_read   = 1'b0;
    nxt_mem_write  = 1'b0;
    nxt_mem_to_reg = 1'b0;
    if (i_valid && !i_ex_flush && !hazard) begin
      case (opcode)
        OP_RTYPE: begin
          nxt_valid = 1'b1; nxt_code = i_instruction[5:0]; nxt_sext = sext_imm;
          nxt_write_reg = rd; nxt_reg_write = 1'b1;
        end
        OP_ADDI: begin
          nxt_valid = 1'b1; nxt_code = ALU_ADD; nxt_sext = sext_imm; nxt_sel_b = 1'b1;
          nxt_write_reg = rt; nxt_reg_write = 1'b1;
        end
        OP_ANDI, OP_ORI: begin
          nxt_valid = 1'b1; nxt_code = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
          nxt_sext = zext_imm; nxt_sel_b = 1'b1;
          nxt_write_reg = rt; nxt_reg_write = 1'b1;
        end
        OP_LW: begin
          nxt_valid = 1'b1; nxt_code = ALU_ADD; nxt_sext = sext_imm; nxt_sel_b = 1'b1;
          nxt_write_reg = rt; nxt_reg_write = 1'b1; nxt_mem_read = 1'b1; nxt_mem_to_reg = 1'b1;
        end
        OP_SW: begin
          nxt_valid = 1'b1; nxt_code = ALU_ADD; nxt_sext = sext_imm; nxt_sel_b = 1'b1;
          nxt_write_reg = rt; nxt_mem_write = 1'b1;
        end
        default: ;
      endcase
      // unsupported opcodes leave nxt_valid low and fall through as a bubble
      if (nxt_valid) begin
        nxt_pc     = i_pc;
        nxt_rs     = rs;
        nxt_rt     = rt;
        nxt_data_1 = rd_data_1;
        nxt_data_2 = rd_data_2;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      o_valid          <= 1'b0;
      o_pc             <= '0;
      o_sign_extend    <= '0;
      o_data_1         <= '0;
      o_data_2         <= '0;
      o_code           <= '0;
      o_selector_mux_A <= 1'b0;
      o_selector_mux_B <= 1'b0;
      o_rs             <= '0;
      o_rt             <= '0;
      o_write_reg      <= '0;
      o_reg_write      <= 1'b0;
      o_mem_read       <= 1'b0;
      o_mem_write      <= 1'b0;
      o_mem_to_reg     <= 1'b0;
    end else begin
      if (i_wb_enable && (i_wb_addr != '0)) regs[i_wb_addr] <= i_wb_data;
      o_valid          <= nxt_valid;
      o_pc             <= nxt_pc;
      o_sign_extend    <= nxt_sext;
      o_data_1         <= nxt_data_1;
      o_data_2         <= nxt_data_2;
      o_code           <= nxt_code;
      o_selector_mux_A <= nxt_sel_a;
      o_selector_mux_B <= nxt_sel_b;
      o_rs             <= nxt_rs;
      o_rt             <= nxt_rt;
      o_write_reg      <= nxt_write_reg;
      o_reg_write      <= nxt_reg_write;
      o_mem_read       <= nxt_mem_read;
      o_mem_write      <= nxt_mem_write;
      o_mem_to_reg     <= nxt_mem_to_reg;
    end
  end

endmodule
